alu_cmd_issuer: RTL and testbench

- Initiator side of the ALU operand/opcode interface: accepts ALU commands on a valid/ready stream and drives registered A/B/ALUOp onto a combinational ALU.
- Captures the ALU result C, optionally compares it to an expected value, and presents the result on a valid/ready response stream.
- Keeps saturating pass/fail counters.
- Sits between the test/sequencing logic and the alu block. Used for self-checking ALU regression and as a reusable operand-issue front end.

---
 rtl/alu_cmd_issuer.sv | 130 +++++++++++++
 tb/tb_alu_cmd_issuer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Purpose : issue ALU commands (A/B/op) from a valid/ready stream to a combinational ALU,
//           capture the result, optionally check it against an expected value, count pass/fail.
// Latency : 2 cycles from handshake to rsp_valid; 1 command/cycle while rsp_ready is high.
// Backpressure: rsp_valid && !rsp_ready freezes S1, S2 and alu_*; cmd_ready drops only when S1 is full.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake; cmd_op/a/b/exp/chk carry the command
//   alu_a/alu_b/alu_op     registered operands to the ALU; alu_c is its combinational result
//   rsp_valid/rsp_ready    response handshake; rsp_c is the result, rsp_mismatch the check outcome
//   clr_cnt                synchronous clear of pass_cnt/fail_cnt (wins over an increment)
//   pass_cnt/fail_cnt      saturating counts of checked commands that matched / mismatched
//   busy                   a command is in S1 or a response is pending
module alu_cmd_issuer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [WIDTH-1:0] cmd_exp,
    input  logic             cmd_chk,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_c,
    output logic             rsp_mismatch,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // S1 (issue) state beyond the alu_* outputs
    logic             s1_valid;
    logic [WIDTH-1:0] s1_exp;
    logic             s1_chk;

    logic s2_free;
    logic s1_adv;
    logic cmd_acc;
    logic s1_match;

    // S2 can take a new result when it is empty or its result leaves this cycle.
    assign s2_free  = !rsp_valid || rsp_ready;
    assign s1_adv   = s1_valid && s2_free;
    // Ready depends only on pipeline state, never on cmd_valid.
    assign cmd_ready = !s1_valid || s2_free;
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign s1_match  = (alu_c == s1_exp);
    assign busy      = s1_valid || rsp_valid;

    // ---------------------------------------------------------------------
    // S1: issue registers. alu_* keep their last values once S1 drains so
    // the ALU inputs do not toggle needlessly.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            s1_exp   <= '0;
            s1_chk   <= 1'b0;
            s1_valid <= 1'b0;
        end else begin
            if (cmd_acc) begin
                alu_a    <= cmd_a;
                alu_b    <= cmd_b;
                alu_op   <= cmd_op;
                s1_exp   <= cmd_exp;
                s1_chk   <= cmd_chk;
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // S2: response registers. A capture in the same cycle as a response
    // handshake simply overwrites, giving back-to-back responses.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_c        <= '0;
            rsp_mismatch <= 1'b0;
            rsp_valid    <= 1'b0;
        end else begin
            if (s1_adv) begin
                rsp_c        <= alu_c;
                rsp_mismatch <= s1_chk && !s1_match;
                rsp_valid    <= 1'b1;
            end else if (rsp_ready) begin
                rsp_valid    <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Saturating pass/fail counters, updated on the capture edge of checked
    // commands. A clear in the same cycle wins over the increment.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (s1_adv && s1_chk) begin
            if (s1_match) begin
                if (pass_cnt != CNT_MAX) begin
                    pass_cnt <= pass_cnt + CNT_ONE;
                end
            end else begin
                if (fail_cnt != CNT_MAX) begin
                    fail_cnt <= fail_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: a reference ALU feeds alu_c, and a queue model of
// the in-flight commands predicts every output each cycle.
module tb_alu_cmd_issuer;

    localparam int W    = 32;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_chk;
    logic [2:0]    cmd_op, alu_op;
    logic [W-1:0]  cmd_a, cmd_b, cmd_exp;
    logic [W-1:0]  alu_a, alu_b, alu_c, rsp_c;
    logic          rsp_valid, rsp_ready, rsp_mismatch, clr_cnt, busy;
    logic [CW-1:0] pass_cnt, fail_cnt;

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = {{(W-1){1'b0}}, (a < b)};
            3'd6:    r = a << b[4:0];
            default: r = ~(a | b);
        endcase
        return r;
    endfunction

    assign alu_c = alu_ref(alu_op, alu_a, alu_b);

    alu_cmd_issuer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_exp(cmd_exp), .cmd_chk(cmd_chk),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
        .rsp_mismatch(rsp_mismatch), .clr_cnt(clr_cnt),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .busy(busy)
    );

    // ------------------------------------------------------------------
    // Reference model: ordered list of accepted commands not yet handed
    // out; m_shown says the oldest one is currently presented as response.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e;
        logic         chk;
    } cmd_t;

    cmd_t         mq[$];
    bit           m_shown = 0;
    bit           m_acc   = 0;
    int           m_pass  = 0;
    int           m_fail  = 0;
    logic [2:0]   m_op    = '0;
    logic [W-1:0] m_a     = '0;
    logic [W-1:0] m_b     = '0;
    int           n_acc   = 0;
    int           n_rsp   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge();
        cmd_t         c;
        logic [W-1:0] r;
        bit           s1h, s2f, adv;
        m_acc = 0;
        if (reset) begin
            mq.delete();
            m_shown = 0; m_pass = 0; m_fail = 0;
            m_op = '0; m_a = '0; m_b = '0;
            return;
        end
        s1h   = mq.size() > (m_shown ? 1 : 0);
        s2f   = !m_shown || rsp_ready;
        adv   = s1h && s2f;
        m_acc = cmd_valid && (!s1h || s2f);
        if (m_shown && rsp_ready) begin
            void'(mq.pop_front());
            m_shown = 0;
            n_rsp++;
        end
        if (adv) begin
            c = mq[0];
            r = alu_ref(c.op, c.a, c.b);
            m_shown = 1;
            if (c.chk) begin
                if (r == c.e) begin
                    if (m_pass < CMAX) m_pass++;
                end else if (m_fail < CMAX) begin
                    m_fail++;
                end
            end
        end
        if (clr_cnt) begin
            m_pass = 0;
            m_fail = 0;
        end
        if (m_acc) begin
            c.op = cmd_op; c.a = cmd_a; c.b = cmd_b; c.e = cmd_exp; c.chk = cmd_chk;
            mq.push_back(c);
            m_op = cmd_op; m_a = cmd_a; m_b = cmd_b;
            n_acc++;
        end
    endtask

    task automatic compare_all();
        bit           s1h;
        logic [W-1:0] r;
        s1h = mq.size() > (m_shown ? 1 : 0);
        check("cmd_ready", cmd_ready, !s1h || !m_shown || rsp_ready);
        check("rsp_valid", rsp_valid, m_shown);
        check("busy", busy, s1h || m_shown);
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_op", alu_op, m_op);
        check("pass_cnt", pass_cnt, m_pass);
        check("fail_cnt", fail_cnt, m_fail);
        if (m_shown) begin
            r = alu_ref(mq[0].op, mq[0].a, mq[0].b);
            check("rsp_c", rsp_c, r);
            check("rsp_mismatch", rsp_mismatch, mq[0].chk && (r != mq[0].e));
        end
    endtask

    // Inputs are only changed at the falling edge, after the comparison.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic put(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] e, input logic c);
        cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_exp = e; cmd_chk = c;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_acc) break;
        end
        if (!m_acc) check("accept_timeout", 64'd0, 64'd1);
        cmd_valid = 0;
    endtask

    cmd_t bp[3];

    initial begin
        int cnt, idx, acc0, rsp0;
        reset = 1; cmd_valid = 0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_exp = '0;
        cmd_chk = 0; rsp_ready = 1; clr_cnt = 0;
        tick();
        tick();
        // reset values
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_c", rsp_c, 0);
        check("rst_rsp_mismatch", rsp_mismatch, 0);
        check("rst_pass", pass_cnt, 0);
        check("rst_fail", fail_cnt, 0);
        check("rst_busy", busy, 0);
        reset = 0;
        tick();
        check("ready_after_rst", cmd_ready, 1);

        // add 1+2, expect 3: response two cycles after presentation
        cmd_valid = 1; cmd_op = 3'd0; cmd_a = 1; cmd_b = 2; cmd_exp = 3; cmd_chk = 1;
        tick();
        cmd_valid = 0;
        check("lat_not_yet", rsp_valid, 0);
        tick();
        check("lat_rsp_valid", rsp_valid, 1);
        check("add_rsp_c", rsp_c, 3);
        check("add_mismatch", rsp_mismatch, 0);
        check("add_pass", pass_cnt, 1);

        // sub 3-2 = 1, expected 5 -> mismatch
        put(3'd1, 3, 2, 5, 1);
        tick();
        check("sub_rsp_c", rsp_c, 1);
        check("sub_mismatch", rsp_mismatch, 1);
        check("sub_fail", fail_cnt, 1);
        check("sub_pass", pass_cnt, 1);

        // 5 back-to-back commands
        acc0 = n_acc; cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) begin
                cmd_valid = 1; cmd_op = 3'(i); cmd_a = 100 + i; cmd_b = 7; cmd_exp = 0; cmd_chk = 0;
            end else begin
                cmd_valid = 0;
            end
            tick();
            if (rsp_valid) cnt++;
        end
        check("stream_accepts", n_acc - acc0, 5);
        check("stream_rsp_cycles", cnt, 5);

        // backpressure: 3 commands offered, only 2 fit
        bp[0] = '{op: 3'd0, a: 10, b: 20, e: 30, chk: 1'b0};
        bp[1] = '{op: 3'd4, a: 'hFF, b: 'h0F, e: 0, chk: 1'b0};
        bp[2] = '{op: 3'd3, a: 'h100, b: 1, e: 0, chk: 1'b0};
        rsp_ready = 0; acc0 = n_acc; idx = 0;
        cmd_valid = 1; cmd_op = bp[0].op; cmd_a = bp[0].a; cmd_b = bp[0].b;
        cmd_exp = bp[0].e; cmd_chk = bp[0].chk;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (m_acc) begin
                idx++;
                if (idx < 3) begin
                    cmd_op = bp[idx].op; cmd_a = bp[idx].a; cmd_b = bp[idx].b;
                    cmd_exp = bp[idx].e; cmd_chk = bp[idx].chk;
                end else cmd_valid = 0;
            end
            if (rsp_valid) check("bp_rsp_c_held", rsp_c, 30);
        end
        check("bp_accepts", n_acc - acc0, 2);
        check("bp_ready_low", cmd_ready, 0);
        rsp_ready = 1; rsp0 = n_rsp;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_acc) begin
                idx++;
                cmd_valid = 0;
            end
        end
        check("bp_drained", n_rsp - rsp0, 3);
        check("bp_all_accepted", idx, 3);

        // saturation at 3 with CNT_W=2
        clr_cnt = 1; tick(); clr_cnt = 0;
        for (int i = 0; i < 5; i++) put(3'd0, i, 1, i + 1, 1);
        tick(); tick();
        check("sat_pass", pass_cnt, 3);
        check("sat_fail", fail_cnt, 0);

        // clear wins over a pass in the same cycle
        put(3'd2, 'hF0, 'h3C, 'h30, 1);
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        check("clr_pass", pass_cnt, 0);
        check("clr_rsp_c", rsp_c, 'h30);
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            clr_cnt   = ($urandom_range(0, 49) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!cmd_valid || m_acc) begin
                cmd_valid = ($urandom_range(0, 9) < 7);
                cmd_op    = 3'($urandom_range(0, 7));
                cmd_a     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                cmd_b     = $urandom_range(0, 1) ? $urandom_range(0, 40) : $urandom;
                cmd_chk   = $urandom_range(0, 1);
                cmd_exp   = $urandom_range(0, 1) ? alu_ref(cmd_op, cmd_a, cmd_b) : $urandom;
            end
            tick();
        end
        reset = 0; clr_cnt = 0; cmd_valid = 0; rsp_ready = 1;
        tick(); tick();

        // reset with two commands in flight
        rsp_ready = 0;
        put(3'd0, 5, 5, 10, 1);
        put(3'd0, 6, 6, 12, 1);
        check("inflight_busy", busy, 1);
        reset = 1;
        tick();
        reset = 0;
        check("rstmid_rsp_valid", rsp_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_pass", pass_cnt, 0);
        check("rstmid_fail", fail_cnt, 0);
        rsp_ready = 1; cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid) cnt++;
        end
        check("rstmid_no_late_rsp", cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
